// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the N-channel arbitrated output register.
package mux_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    // Select fields must stay at least one bit wide, even for degenerate channel counts.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// Combinational arbiter: fixed priority from index 0, or round-robin search from ptr.
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int        N_CH     = 4,
    parameter arb_mode_t ARB_MODE = ARB_RR,
    parameter int        SEL_W    = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    int   start;
    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        start     = 0;
        if (ARB_MODE == ARB_RR) begin
            start = int'(ptr);
            // A pointer outside the channel range cannot occur, but restarting at 0 keeps it harmless.
            if (start >= N_CH) begin
                start = 0;
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            idx = start + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel registered mux: arbitrates valid/ready producers into one output register.
module mux_arb_n
    import mux_arb_pkg::*;
#(
    parameter int        N_CH     = 4,
    parameter int        WIDTH    = 4,
    parameter arb_mode_t ARB_MODE = ARB_RR,
    parameter int        SEL_W    = clog2_min1(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  in_valid,
    output logic [N_CH-1:0]  in_ready,
    input  logic [WIDTH-1:0] in_data [0:N_CH-1],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_sel
);

    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] ptr;
    logic             load_en;
    logic             any_grant;

    rr_arbiter #(
        .N_CH     (N_CH),
        .ARB_MODE (ARB_MODE),
        .SEL_W    (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign load_en   = !out_valid || out_ready;
    assign any_grant = |grant;
    assign in_ready  = grant & {N_CH{load_en}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load_en) begin
            if (any_grant) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_idx];
                out_sel   <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Pointer advances past the accepted channel; explicit wrap covers non-power-of-2 N_CH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (ARB_MODE == ARB_RR && load_en && any_grant) begin
            if (grant_idx == SEL_W'(N_CH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + SEL_W'(1);
            end
        end
    end

endmodule
